// File: rtl/hw_call_stack_pkg.sv
// hw_call_stack_pkg
// Shared constants and the per-cycle stack operation type for the hardware
// call stack. No ports.
package hw_call_stack_pkg;

  localparam int WORD_W      = 16;
  localparam int STACK_DEPTH = 16;

  // Operation actually carried out on the storage this cycle. Refused
  // pushes and pops (full/empty) map to OP_NONE; the error flags are
  // derived separately.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } stack_op_t;

endpackage : hw_call_stack_pkg

// File: rtl/hw_call_stack_if.sv
// hw_call_stack_if
// Decoder <-> call stack signal bundle.
//   master (decoder): drives push_en, pop_en, push_data, clr_err;
//                     observes top_data, stack_full, stack_empty, count,
//                     overflow, underflow.
//   slave  (stack)  : the reverse.
interface hw_call_stack_if
  import hw_call_stack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             push_en;
  logic             pop_en;
  logic [WIDTH-1:0] push_data;
  logic             clr_err;
  logic [WIDTH-1:0] top_data;
  logic             stack_full;
  logic             stack_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_en, pop_en, push_data, clr_err,
    input  top_data, stack_full, stack_empty, count, overflow, underflow
  );

  modport slave (
    input  push_en, pop_en, push_data, clr_err,
    output top_data, stack_full, stack_empty, count, overflow, underflow
  );

endinterface : hw_call_stack_if

// File: rtl/hw_call_stack_regfile.sv
// hw_call_stack_regfile
// Stack storage: DEPTH x WIDTH register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data (combinational)
module hw_call_stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : hw_call_stack_regfile

// File: rtl/hw_call_stack.sv
// hw_call_stack
// LIFO call stack fed by the instruction decoder's push/pop strobes.
// top_data is a zero-latency read of the top entry so a pop completes in the
// same cycle it is strobed; full/empty/count decode only from the registered
// pointer, keeping them free of any path from push_en/pop_en.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hw_call_stack_if.slave (strobes, data, status, sticky errors)
module hw_call_stack
  import hw_call_stack_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  hw_call_stack_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    r_sp;
  logic             r_ovf;
  logic             r_udf;

  stack_op_t        w_op;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf_evt;
  logic             w_udf_evt;
  logic             w_we;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_rd_data;

  assign w_full  = (r_sp == CW'(DEPTH));
  assign w_empty = (r_sp == '0);

  always_comb begin
    w_op = OP_NONE;
    case ({bus.push_en, bus.pop_en})
      2'b10:   if (!w_full)  w_op = OP_PUSH;
      2'b01:   if (!w_empty) w_op = OP_POP;
      // Push+pop on an empty stack still pushes (the pop part is the error).
      2'b11:   w_op = w_empty ? OP_PUSH : OP_REPL;
      default: w_op = OP_NONE;
    endcase
  end

  // A simultaneous pop frees the slot, so a full stack never overflows on push+pop.
  assign w_ovf_evt = bus.push_en & ~bus.pop_en & w_full;
  assign w_udf_evt = bus.pop_en & w_empty;

  // On empty the top index wraps to DEPTH-1; harmless since top_data is masked.
  assign w_top_idx = AW'(r_sp - CW'(1));
  assign w_wr_addr = (w_op == OP_REPL) ? w_top_idx : AW'(r_sp);
  assign w_we      = (w_op == OP_PUSH) || (w_op == OP_REPL);

  hw_call_stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (bus.push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_sp <= r_sp + CW'(1);
        OP_POP:  r_sp <= r_sp - CW'(1);
        default: r_sp <= r_sp;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle beats clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)        r_ovf <= 1'b1;
      else if (bus.clr_err) r_ovf <= 1'b0;
      if (w_udf_evt)        r_udf <= 1'b1;
      else if (bus.clr_err) r_udf <= 1'b0;
    end
  end

  assign bus.top_data    = w_empty ? '0 : w_rd_data;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.count       = r_sp;
  assign bus.overflow    = r_ovf;
  assign bus.underflow   = r_udf;

endmodule : hw_call_stack
